mxv_row_sequencer: RTL and testbench
====================================

// Module: mxv_row_sequencer
// PURPOSE
//  Control/datapath stage that consumes the flags of the modulo-COLUMNS column counter of the MxV datapath.
//  Drives the counter's enable and multiply-accumulates one matrix row against the vector per counter wrap.
//  Emits one dot-product result per row, and a done pulse after ROWS rows.
//  Sits between the element source (upstream) and the result sink (downstream).
// PARAMETERS
//  DATA_WIDTH = 8             unsigned width of matrix and vector elements
//  COLUMNS    = 36            elements per row; equals the column counter's MAXIMUM_VALUE
//  ROWS       = 4             rows per operation, >= 1
//  ROW_BITS   = CeilLog2(ROWS) (min 1)         width of row index
//  ACC_WIDTH  = 2*DATA_WIDTH + CeilLog2(COLUMNS) accumulator/result width; guarantees no overflow
// PORTS
//  clk            in   1          rising-edge clock
//  reset          in   1          asynchronous, active-low reset
//  start          in   1          begin a new MxV operation; sampled in IDLE only
//  elem_valid     in   1          mat_elem/vec_elem valid this cycle
//  mat_elem       in   DATA_WIDTH matrix element, row-major order
//  vec_elem       in   DATA_WIDTH matching vector element
//  col_flag0      in   1          column counter at 0; first element of a row
//  col_flag_max   in   1          column counter at COLUMNS-1; last element of a row
//  col_enable     out  1          advance column counter; = elem_valid & elem_ready, combinational
//  elem_ready     out  1          sequencer accepts elements; high only in RUN
//  result         out  ACC_WIDTH  dot product of the last completed row; held until the next row completes
//  result_valid   out  1          one-cycle pulse; result is new this cycle
//  row_index      out  ROW_BITS   row number of the current result
//  busy           out  1          high in RUN and DONE
//  done           out  1          one-cycle pulse after the last row's result_valid
// BEHAVIOUR
//  Reset: state=IDLE. result, result_valid, row_index, done, busy, elem_ready, col_enable and the accumulator are all 0.
//  Reset asserted mid-operation aborts immediately; the column counter shares the same reset.
//  IDLE: start=1 -> RUN on the next edge, with row counter=0. elem_valid is ignored; col_enable=0.
//  RUN: each accepted element (elem_valid & elem_ready) forms prod = mat_elem*vec_elem, unsigned, full width.
//   - col_flag0=1: acc <= prod. The row restarts regardless of stale acc.
//   - otherwise: acc <= acc + prod.
//   - col_flag_max=1 (also with flag0 when COLUMNS=1): result <= acc_next and row_index <= row counter.
//     result_valid=1 on the following cycle, i.e. 1-cycle latency from the last element. Then row counter++.
//   - Last row accepted (row counter==ROWS-1 and flag_max): next state=DONE; elem_ready drops next cycle.
//  Without elem_valid: no accumulation, col_enable=0, and the counter holds. Gaps of any length are legal.
//  DONE: done=1 for exactly one cycle, coinciding with the final result_valid -> IDLE.
//  start in RUN/DONE: ignored (no restart, no error).
//  Simultaneous start and reset: reset wins.
//  Counter wrap from COLUMNS-1 to 0 is owned by the counter; this block relies only on the flags.
//  Row counter wraps only through the IDLE reinit.
// STRUCTURE
//  Package mxv_pkg:
//   - state typedef enum logic [1:0] {IDLE, RUN, DONE}
//   - CeilLog2 function
//   - default DATA_WIDTH/COLUMNS/ROWS localparams shared with the counter instance
//  Sub-module mxv_mac: registered multiply-accumulate with load (flag0) and enable.
//  FSM, row counter and result register stay in this module.
// TESTING
//  1. Reset mid-RUN, after 10 elements: all outputs 0 next cycle, state IDLE; a fresh start then yields correct results.
//  2. COLUMNS=36, ROWS=4, all elements 1, continuous valid, start pulse:
//     result_valid pulses every 36 cycles, result=36, row_index=0..3, done aligned with the 4th pulse.
//  3. Max values 255*255 for all 36 elements: result=2,340,900, with no overflow in ACC_WIDTH=22.
//  4. elem_valid toggling 1-0-1-0, mat=i, vec=2: row0 result = 2*sum(0..35) = 1260.
//     col_enable mirrors the accepted cycles only.
//  5. start held high throughout: exactly one operation runs; a second begins only after returning to IDLE.
//  6. COLUMNS=1, ROWS=3, pairs (3,4),(5,6),(7,8): results 12, 30, 56 on consecutive result_valid pulses, then done.

Source files
------------

// File: rtl/mxv_pkg.sv
// -----------------------------------------------------------------------------
// mxv_pkg
// Shared definitions for the MxV row sequencer and its column counter:
//   - state_t       : sequencer FSM states
//   - DEF_*         : default geometry shared with the column counter instance
//   - ceil_log2()   : constant function used to size row index and accumulator
// No ports (package).
// -----------------------------------------------------------------------------
package mxv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_COLUMNS    = 36;
    localparam int DEF_ROWS       = 4;

    // Smallest n with 2**n >= value; value 0 or 1 gives 0.
    function automatic int ceil_log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mxv_row_sequencer_if.sv
// -----------------------------------------------------------------------------
// mxv_row_sequencer_if
// Element stream between the element source / column counter (master side)
// and the row sequencer (slave side).
//   elem_valid, mat_elem, vec_elem : element pair offered by the source
//   col_flag0, col_flag_max        : column counter at 0 / at COLUMNS-1
//   elem_ready                     : sequencer accepts elements
//   col_enable                     : advance the column counter
// -----------------------------------------------------------------------------
interface mxv_row_sequencer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  elem_valid;
    logic [DATA_WIDTH-1:0] mat_elem;
    logic [DATA_WIDTH-1:0] vec_elem;
    logic                  col_flag0;
    logic                  col_flag_max;
    logic                  elem_ready;
    logic                  col_enable;

    modport master (
        output elem_valid, mat_elem, vec_elem, col_flag0, col_flag_max,
        input  elem_ready, col_enable
    );

    modport slave (
        input  elem_valid, mat_elem, vec_elem, col_flag0, col_flag_max,
        output elem_ready, col_enable
    );
endinterface

// File: rtl/mxv_mac.sv
// -----------------------------------------------------------------------------
// mxv_mac
// Registered unsigned multiply-accumulate.
//   clk, reset : clock, asynchronous active-low reset
//   en         : accumulate this cycle
//   load       : with en, start a new sum from the current product
//   a, b       : DATA_WIDTH operands
//   acc_d      : value the accumulator takes on the next edge
// -----------------------------------------------------------------------------
module mxv_mac
    import mxv_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = 2 * DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  acc_d
);

    logic [2*DATA_WIDTH-1:0] prod_s;
    logic [ACC_WIDTH-1:0]    acc_q;

    assign prod_s = a * b;

    // Next accumulator value: load restarts the row regardless of stale contents.
    always_comb begin
        acc_d = acc_q;
        if (en) begin
            if (load) begin
                acc_d = ACC_WIDTH'(prod_s);
            end else begin
                acc_d = acc_q + ACC_WIDTH'(prod_s);
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= {ACC_WIDTH{1'b0}};
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/mxv_row_sequencer.sv
// -----------------------------------------------------------------------------
// mxv_row_sequencer
// Accepts matrix/vector element pairs row by row, accumulates one dot product
// per column-counter wrap, emits it with its row number, and pulses done with
// the last row's result.
//   clk, reset   : clock, asynchronous active-low reset
//   start        : begin an operation (only looked at in IDLE)
//   elem_if      : element stream + column counter flags/enable (slave)
//   result       : dot product of the last completed row (held)
//   result_valid : one-cycle pulse, result is new
//   row_index    : row number belonging to result
//   busy         : operation in progress (RUN or DONE)
//   done         : one-cycle pulse together with the final result_valid
// -----------------------------------------------------------------------------
module mxv_row_sequencer
    import mxv_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int COLUMNS    = DEF_COLUMNS,
    parameter int ROWS       = DEF_ROWS,
    localparam int ROW_BITS  = (ceil_log2(ROWS) < 1) ? 1 : ceil_log2(ROWS),
    localparam int ACC_WIDTH = 2 * DATA_WIDTH + ceil_log2(COLUMNS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    mxv_row_sequencer_if.slave    elem_if,
    output logic [ACC_WIDTH-1:0]  result,
    output logic                  result_valid,
    output logic [ROW_BITS-1:0]   row_index,
    output logic                  busy,
    output logic                  done
);

    state_t                state_q, state_d;
    logic [ROW_BITS-1:0]   row_q, row_d;
    logic [ACC_WIDTH-1:0]  result_q, result_d;
    logic                  result_valid_q, result_valid_d;
    logic [ROW_BITS-1:0]   row_index_q, row_index_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  elem_ready_q, elem_ready_d;

    logic                  accept_s;
    logic                  row_end_s;
    logic                  last_row_s;
    logic [ACC_WIDTH-1:0]  acc_d_s;

    assign accept_s   = elem_if.elem_valid & elem_ready_q;
    assign row_end_s  = accept_s & elem_if.col_flag_max;
    assign last_row_s = (row_q == ROW_BITS'(ROWS - 1));

    assign elem_if.elem_ready = elem_ready_q;
    // The counter must advance in the same cycle the element is taken.
    assign elem_if.col_enable = accept_s;

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign row_index    = row_index_q;
    assign busy         = busy_q;
    assign done         = done_q;

    mxv_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .en    (accept_s),
        .load  (elem_if.col_flag0),
        .a     (elem_if.mat_elem),
        .b     (elem_if.vec_elem),
        .acc_d (acc_d_s)
    );

    // FSM next state, row counter and result capture.
    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        row_index_d    = row_index_q;
        done_d         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    row_d   = {ROW_BITS{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (row_end_s) begin
                    result_d       = acc_d_s;
                    row_index_d    = row_q;
                    result_valid_d = 1'b1;
                    if (last_row_s) begin
                        // Row counter is left alone; IDLE reinitialises it.
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        row_d = row_q + ROW_BITS'(1);
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d       = (state_d != IDLE);
        elem_ready_d = (state_d == RUN);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            row_q          <= {ROW_BITS{1'b0}};
            result_q       <= {ACC_WIDTH{1'b0}};
            result_valid_q <= 1'b0;
            row_index_q    <= {ROW_BITS{1'b0}};
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
            elem_ready_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            row_q          <= row_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            row_index_q    <= row_index_d;
            done_q         <= done_d;
            busy_q         <= busy_d;
            elem_ready_q   <= elem_ready_d;
        end
    end

endmodule

// File: tb/tb_mxv_row_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mxv_row_sequencer
// Two sequencer instances: A (36 columns, 4 rows) fed by a modulo-36 column
// counter model, and B (1 column, 3 rows) whose counter sits at 0 == COLUMNS-1.
// Expected row results are queued as rows are driven and compared when
// result_valid pulses.
// -----------------------------------------------------------------------------
module tb_mxv_row_sequencer;

    localparam int A_COLS = 36;
    localparam int A_ROWS = 4;
    localparam int B_ROWS = 3;

    typedef struct {
        logic [31:0] res;
        logic [31:0] row;
        logic [31:0] done;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic a_rst_n = 1'b0;
    logic b_rst_n = 1'b0;
    logic a_start = 1'b0;
    logic b_start = 1'b0;

    logic [21:0] a_result;
    logic        a_rv;
    logic [1:0]  a_row;
    logic        a_busy;
    logic        a_done;
    logic [15:0] b_result;
    logic        b_rv;
    logic [1:0]  b_row;
    logic        b_busy;
    logic        b_done;

    logic [5:0]  a_cnt;

    exp_t exp_a[$];
    exp_t exp_b[$];
    int   a_rv_cyc[$];
    int   b_rv_cyc[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    mxv_row_sequencer_if #(.DATA_WIDTH(8)) a_if ();
    mxv_row_sequencer_if #(.DATA_WIDTH(8)) b_if ();

    mxv_row_sequencer #(.DATA_WIDTH(8), .COLUMNS(A_COLS), .ROWS(A_ROWS)) u_dut_a (
        .clk          (clk),
        .reset        (a_rst_n),
        .start        (a_start),
        .elem_if      (a_if.slave),
        .result       (a_result),
        .result_valid (a_rv),
        .row_index    (a_row),
        .busy         (a_busy),
        .done         (a_done)
    );

    mxv_row_sequencer #(.DATA_WIDTH(8), .COLUMNS(1), .ROWS(B_ROWS)) u_dut_b (
        .clk          (clk),
        .reset        (b_rst_n),
        .start        (b_start),
        .elem_if      (b_if.slave),
        .result       (b_result),
        .result_valid (b_rv),
        .row_index    (b_row),
        .busy         (b_busy),
        .done         (b_done)
    );

    // Modulo-36 column counter sharing A's reset.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            a_cnt <= 6'd0;
        end else if (a_if.col_enable) begin
            a_cnt <= (a_cnt == 6'd35) ? 6'd0 : a_cnt + 6'd1;
        end
    end
    assign a_if.col_flag0    = (a_cnt == 6'd0);
    assign a_if.col_flag_max = (a_cnt == 6'd35);
    // A one-column counter never leaves 0, which is also its maximum.
    assign b_if.col_flag0    = 1'b1;
    assign b_if.col_flag_max = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Scoreboard for A.
    always @(negedge clk) begin
        exp_t e;
        if (a_rv === 1'b1) begin
            a_rv_cyc.push_back(cyc);
            if (exp_a.size() == 0) begin
                check_val("a_rv_unexpected", 32'(a_rv), 32'(exp_a.size()));
            end else begin
                e = exp_a.pop_front();
                check_val("a_result", 32'(a_result), e.res);
                check_val("a_row_index", 32'(a_row), e.row);
                check_val("a_done", 32'(a_done), e.done);
            end
        end else if (a_done !== 1'b0) begin
            check_val("a_done_without_rv", 32'(a_done), 32'd0);
        end
    end

    // Scoreboard for B.
    always @(negedge clk) begin
        exp_t e;
        if (b_rv === 1'b1) begin
            b_rv_cyc.push_back(cyc);
            if (exp_b.size() == 0) begin
                check_val("b_rv_unexpected", 32'(b_rv), 32'(exp_b.size()));
            end else begin
                e = exp_b.pop_front();
                check_val("b_result", 32'(b_result), e.res);
                check_val("b_row_index", 32'(b_row), e.row);
                check_val("b_done", 32'(b_done), e.done);
            end
        end else if (b_done !== 1'b0) begin
            check_val("b_done_without_rv", 32'(b_done), 32'd0);
        end
    end

    task automatic drive_a(input logic valid, input logic [7:0] m, input logic [7:0] v, input bit chk_en);
        a_if.elem_valid = valid;
        a_if.mat_elem   = m;
        a_if.vec_elem   = v;
        #2;
        if (chk_en) check_val("a_col_enable", 32'(a_if.col_enable), 32'(valid));
        @(posedge clk);
        #1;
    endtask

    task automatic drain_a();
        for (int i = 0; i < 200 && exp_a.size() != 0; i++) @(posedge clk);
        check_val("a_drain_timeout", 32'(exp_a.size()), 32'd0);
        #1;
    endtask

    task automatic drain_b();
        for (int i = 0; i < 50 && exp_b.size() != 0; i++) @(posedge clk);
        check_val("b_drain_timeout", 32'(exp_b.size()), 32'd0);
        #1;
    endtask

    // mode: 0 ones, 1 max, 2 mat=col/vec=2, else random.
    // start_ctl: 0 pulse start, 1 raise and hold start, 2 already in RUN.
    task automatic run_op_a(input int mode, input bit gaps, input int start_ctl);
        logic [7:0]  m [A_COLS];
        logic [7:0]  v [A_COLS];
        logic [31:0] sum;
        if (start_ctl != 2) begin
            a_start = 1'b1;
            @(posedge clk);
            #1;
            if (start_ctl == 0) a_start = 1'b0;
        end
        for (int r = 0; r < A_ROWS; r++) begin
            sum = 32'd0;
            for (int c = 0; c < A_COLS; c++) begin
                case (mode)
                    0:       begin m[c] = 8'd1;   v[c] = 8'd1;   end
                    1:       begin m[c] = 8'd255; v[c] = 8'd255; end
                    2:       begin m[c] = 8'(c);  v[c] = 8'd2;   end
                    default: begin m[c] = 8'($urandom_range(0, 255)); v[c] = 8'($urandom_range(0, 255)); end
                endcase
                sum = sum + 32'(m[c]) * 32'(v[c]);
            end
            exp_a.push_back('{sum, 32'(r), (r == A_ROWS - 1) ? 32'd1 : 32'd0});
            for (int c = 0; c < A_COLS; c++) begin
                drive_a(1'b1, m[c], v[c], gaps);
                if (gaps) drive_a(1'b0, 8'hAA, 8'h55, gaps);
            end
        end
        a_if.elem_valid = 1'b0;
        drain_a();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        a_if.elem_valid = 1'b0;
        a_if.mat_elem   = 8'd0;
        a_if.vec_elem   = 8'd0;
        b_if.elem_valid = 1'b1;
        b_if.mat_elem   = 8'd9;
        b_if.vec_elem   = 8'd9;

        // Reset state (B sees valid during reset and must ignore it).
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_a_result", 32'(a_result), 32'd0);
        check_val("rst_a_busy", 32'(a_busy), 32'd0);
        check_val("rst_a_ready", 32'(a_if.elem_ready), 32'd0);
        check_val("rst_b_col_enable", 32'(b_if.col_enable), 32'd0);
        check_val("rst_b_rv", 32'(b_rv), 32'd0);
        @(posedge clk);
        #1;
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        @(posedge clk);
        #1;
        // IDLE ignores elem_valid.
        check_val("idle_b_col_enable", 32'(b_if.col_enable), 32'd0);
        b_if.elem_valid = 1'b0;

        // All ones, continuous: 36 per row, pulses 36 cycles apart.
        a_rv_cyc.delete();
        run_op_a(0, 1'b0, 0);
        check_val("ones_pulse_count", 32'(a_rv_cyc.size()), 32'd4);
        for (int i = 1; i < a_rv_cyc.size(); i++)
            check_val("ones_pulse_spacing", 32'(a_rv_cyc[i] - a_rv_cyc[i-1]), 32'd36);
        @(negedge clk);
        check_val("ones_busy_after", 32'(a_busy), 32'd0);

        // Maximum operands: 36*255*255 = 2340900 fits in 22 bits.
        @(posedge clk);
        #1;
        run_op_a(1, 1'b0, 0);

        // Toggling valid, mat=col, vec=2: 1260 per row; col_enable only on accepts.
        run_op_a(2, 1'b1, 0);

        // Reset mid-row after 10 elements, valid kept high.
        a_start = 1'b1;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        for (int i = 0; i < 10; i++) drive_a(1'b1, 8'd3, 8'd3, 1'b0);
        a_rst_n = 1'b0;
        @(negedge clk);
        check_val("midrst_result", 32'(a_result), 32'd0);
        check_val("midrst_rv", 32'(a_rv), 32'd0);
        check_val("midrst_row", 32'(a_row), 32'd0);
        check_val("midrst_done", 32'(a_done), 32'd0);
        check_val("midrst_busy", 32'(a_busy), 32'd0);
        check_val("midrst_ready", 32'(a_if.elem_ready), 32'd0);
        check_val("midrst_col_enable", 32'(a_if.col_enable), 32'd0);
        @(posedge clk);
        #1;
        a_rst_n = 1'b1;
        a_if.elem_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        run_op_a(3, 1'b0, 0);

        // start held high: one operation, IDLE for one cycle, then a second.
        run_op_a(3, 1'b0, 1);
        @(negedge clk);
        check_val("hold_idle_busy", 32'(a_busy), 32'd0);
        @(posedge clk);
        #1;
        a_start = 1'b0;
        #2;
        check_val("hold_restart_busy", 32'(a_busy), 32'd1);
        run_op_a(3, 1'b0, 2);

        // B: one column, three rows, consecutive results 12, 30, 56.
        b_rv_cyc.delete();
        b_start = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        exp_b.push_back('{32'd12, 32'd0, 32'd0});
        exp_b.push_back('{32'd30, 32'd1, 32'd0});
        exp_b.push_back('{32'd56, 32'd2, 32'd1});
        for (int i = 0; i < 3; i++) begin
            b_if.elem_valid = 1'b1;
            b_if.mat_elem   = 8'(3 + 2 * i);
            b_if.vec_elem   = 8'(4 + 2 * i);
            @(posedge clk);
            #1;
        end
        b_if.elem_valid = 1'b0;
        drain_b();
        check_val("b_pulse_count", 32'(b_rv_cyc.size()), 32'd3);
        for (int i = 1; i < b_rv_cyc.size(); i++)
            check_val("b_pulse_spacing", 32'(b_rv_cyc[i] - b_rv_cyc[i-1]), 32'd1);
        @(negedge clk);
        check_val("b_busy_after", 32'(b_busy), 32'd0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
